// File: rtl/key_event.sv
// Turns debounced key levels into registered per-key events: press, release,
// auto-repeat pulses and a long-press level. Every key channel is independent.
module key_event #(
  parameter int N          = 4,
  parameter int HOLD_CYC   = 1000,
  parameter int REPEAT_CYC = 250,
  parameter int CW         = 21
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_rpt,
  output logic [N-1:0] key_hold
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RPT  = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYC - 1);

  state_t        state     [N];
  state_t        state_nxt [N];
  logic [CW-1:0] cnt       [N];
  logic [CW-1:0] cnt_nxt   [N];

  logic [N-1:0] prev;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] press_nxt;
  logic [N-1:0] release_nxt;
  logic [N-1:0] rpt_nxt;
  logic [N-1:0] hold_nxt;

  assign rise = ~prev & key_in;
  assign fall = prev & ~key_in;

  always_ff @(posedge clk) begin
    if (nrst) begin
      prev        <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_rpt     <= '0;
      key_hold    <= '0;
      for (int i = 0; i < N; i++) begin
        state[i] <= S_IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      prev        <= key_in;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_rpt     <= rpt_nxt;
      key_hold    <= hold_nxt;
      for (int i = 0; i < N; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // A fall always wins over a threshold hit in the same cycle, so the
  // release pulse is never accompanied by a repeat pulse.
  always_comb begin
    press_nxt   = '0;
    release_nxt = '0;
    rpt_nxt     = '0;
    hold_nxt    = key_hold;
    for (int i = 0; i < N; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        S_IDLE: begin
          if (rise[i]) begin
            press_nxt[i] = 1'b1;
            cnt_nxt[i]   = '0;
            state_nxt[i] = S_WAIT;
          end
        end
        S_WAIT: begin
          if (fall[i]) begin
            release_nxt[i] = 1'b1;
            hold_nxt[i]    = 1'b0;
            cnt_nxt[i]     = '0;
            state_nxt[i]   = S_IDLE;
          end else if (key_in[i]) begin
            if (cnt[i] == HOLD_LAST) begin
              rpt_nxt[i]   = 1'b1;
              hold_nxt[i]  = 1'b1;
              cnt_nxt[i]   = '0;
              state_nxt[i] = S_RPT;
            end else begin
              cnt_nxt[i] = cnt[i] + 1'b1;
            end
          end
        end
        S_RPT: begin
          if (fall[i]) begin
            release_nxt[i] = 1'b1;
            hold_nxt[i]    = 1'b0;
            cnt_nxt[i]     = '0;
            state_nxt[i]   = S_IDLE;
          end else if (key_in[i]) begin
            if (cnt[i] == REPEAT_LAST) begin
              rpt_nxt[i] = 1'b1;
              cnt_nxt[i] = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + 1'b1;
            end
          end
        end
        default: begin
          cnt_nxt[i]   = '0;
          state_nxt[i] = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Directed scenarios followed by random key activity, all checked every cycle
// against a reference model that tracks each key's age since its press.
module tb_key_event;

  localparam int N = 4;
  localparam int H = 8;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         nrst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_rpt;
  logic [N-1:0] key_hold;

  int checks = 0;
  int errors = 0;

  // Reference model: a key is "held" from its sampled rise until its sampled
  // fall; age counts clock edges since the rise was sampled.
  bit           m_prev [N];
  bit           m_held [N];
  int           m_age  [N];
  logic [N-1:0] e_press;
  logic [N-1:0] e_release;
  logic [N-1:0] e_rpt;
  logic [N-1:0] e_hold;

  key_event #(.N(N), .HOLD_CYC(H), .REPEAT_CYC(R), .CW(21)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .key_in      (key_in),
    .key_press   (key_press),
    .key_release (key_release),
    .key_rpt     (key_rpt),
    .key_hold    (key_hold)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic [N-1:0] k);
    e_press   = '0;
    e_release = '0;
    e_rpt     = '0;
    if (r) begin
      e_hold = '0;
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 1'b0;
        m_held[i] = 1'b0;
        m_age[i]  = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!m_held[i] && !m_prev[i] && k[i]) begin
          e_press[i] = 1'b1;
          m_held[i]  = 1'b1;
          m_age[i]   = 0;
        end else if (m_held[i] && m_prev[i] && !k[i]) begin
          e_release[i] = 1'b1;
          e_hold[i]    = 1'b0;
          m_held[i]    = 1'b0;
        end else if (m_held[i] && k[i]) begin
          m_age[i] = m_age[i] + 1;
          if (m_age[i] >= H) begin
            e_hold[i] = 1'b1;
            if ((m_age[i] - H) % R == 0) e_rpt[i] = 1'b1;
          end
        end
        m_prev[i] = k[i];
      end
    end
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] k);
    nrst   = r;
    key_in = k;
    @(posedge clk);
    model_edge(r, k);
    #1;
    check("key_press", key_press, e_press);
    check("key_release", key_release, e_release);
    check("key_rpt", key_rpt, e_rpt);
    check("key_hold", key_hold, e_hold);
    check("pulse_exclusive",
          (key_press & key_release) | (key_press & key_rpt) | (key_release & key_rpt),
          4'h0);
  endtask

  task automatic run(input logic r, input logic [N-1:0] k, input int cycles);
    for (int c = 0; c < cycles; c++) step(r, k);
  endtask

  initial begin
    logic [N-1:0] k;
    e_hold = '0;
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 1'b0;
      m_held[i] = 1'b0;
      m_age[i]  = 0;
    end

    // Reset with all keys down-held, then release reset: press on all keys
    run(1'b1, 4'hF, 3);
    run(1'b0, 4'hF, 2);
    run(1'b0, 4'h0, 3);

    // Short press on key 0
    run(1'b0, 4'h1, 5);
    run(1'b0, 4'h0, 3);

    // Long hold on key 1: repeats at +9, +13, +17, release collides at +21
    run(1'b0, 4'h2, 20);
    run(1'b0, 4'h0, 3);

    // Key 2 falls exactly when the hold threshold would fire
    run(1'b0, 4'h4, 8);
    run(1'b0, 4'h0, 3);

    // Reset in the middle of repeating on key 3, key kept held
    run(1'b0, 4'h8, 12);
    run(1'b1, 4'h8, 1);
    run(1'b0, 4'h8, 15);
    run(1'b0, 4'h0, 3);

    // Keys 0 and 1 held concurrently, offset by 3 cycles
    run(1'b0, 4'h1, 3);
    run(1'b0, 4'h3, 20);
    run(1'b0, 4'h2, 3);
    run(1'b0, 4'h0, 3);

    // Random activity with occasional resets
    k = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) k[i] = ~k[i];
      step(($urandom_range(0, 199) == 0), k);
    end
    run(1'b0, 4'h0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
